// File: rtl/pulse_period_meter.sv
// Measures the spacing, in clock cycles, between rising edges of an asynchronous
// pulse train; the inverse of a countdown rate divider.
module pulse_period_meter #(
    parameter int          WIDTH       = 28,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 100_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   pulse_edge;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    // Synchroniser latency is identical for every edge, so it cancels out of the period.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!enable) begin
            state_d   = IDLE;
            count_d   = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    state_d = ARMED;
                end
                ARMED: begin
                    if (pulse_edge) begin
                        count_d = WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge on the TIMEOUT cycle is still a valid measurement, so count never wraps.
                    if (pulse_edge) begin
                        period_d  = count_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        count_d   = WIDTH'(1);
                    end else if (count_q == TIMEOUT_W) begin
                        timeout_d = 1'b1;
                        count_d   = '0;
                        state_d   = ARMED;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign state_dbg    = state_q;

endmodule
